// File: rtl/pcie_drain.sv
// pcie_drain: drains two destination FIFOs (D0/D1) one word at a time into a
// single held output register. The two FIFOs are served round-robin.
// Timing: the pop strobe is in cycle N and valid_out is high from cycle N+2.
// Optional route check: define DRAIN_ROUTE_CHECK_EN to compare the word's
// destination bit (bit4) against the FIFO it came from. A mismatch sets a
// sticky error_out. Without the macro, error_out is tied low.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | nothing in flight; waiting for enable and a non-empty FIFO
// S_POP     | one pop strobe to the selected FIFO this cycle
// S_CAPTURE | FIFO read data valid; register it, bump the per-FIFO count
// S_HOLD    | word presented on data_out until out_ready
module pcie_drain (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       empty_D0,
  input  logic       empty_D1,
  input  logic [5:0] data_in0,
  input  logic [5:0] data_in1,
  input  logic       idle_in,
  input  logic       out_ready,
  output logic       pop_D0,
  output logic       pop_D1,
  output logic [5:0] data_out,
  output logic       valid_out,
  output logic       src_out,
  output logic [7:0] count_D0,
  output logic [7:0] count_D1,
  output logic       done_out,
  output logic       error_out
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_POP     = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  // The FIFO being served, or the one served most recently. It resets to D1
  // so that the first tie after reset goes to D0.
  logic       sel_q, sel_d;
  logic [5:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       src_q, src_d;
  logic [7:0] cnt0_q, cnt0_d;
  logic [7:0] cnt1_q, cnt1_d;
  logic       done_q, done_d;

  logic       avail0, avail1;
  logic       can_pop;
  logic       pick;
  logic [5:0] cap_word;

  // Arbitration: on a tie, serve the FIFO that was not served last.
  always_comb begin
    avail0   = ~empty_D0;
    avail1   = ~empty_D1;
    can_pop  = enable & (avail0 | avail1);
    pick     = (avail0 & avail1) ? ~sel_q : avail1;
    cap_word = sel_q ? data_in1 : data_in0;
  end

`ifdef DRAIN_ROUTE_CHECK_EN
  logic err_q, err_d;
`endif

  // Next-state, datapath and strobe decode.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = valid_q;
    src_d   = src_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    pop_D0  = 1'b0;
    pop_D1  = 1'b0;
`ifdef DRAIN_ROUTE_CHECK_EN
    err_d   = err_q;
`endif
    done_d  = (state_q == S_IDLE) & idle_in & empty_D0 & empty_D1;

    case (state_q)
      S_IDLE: begin
        if (can_pop) begin
          state_d = S_POP;
          sel_d   = pick;
        end
      end
      S_POP: begin
        // The pop is committed once issued, even if the empty flag now rises.
        pop_D0  = ~sel_q;
        pop_D1  = sel_q;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        data_d  = cap_word;
        src_d   = sel_q;
        valid_d = 1'b1;
        if (!sel_q) begin
          if (cnt0_q != 8'hFF) cnt0_d = cnt0_q + 8'd1;
        end else begin
          if (cnt1_q != 8'hFF) cnt1_d = cnt1_q + 8'd1;
        end
`ifdef DRAIN_ROUTE_CHECK_EN
        if (cap_word[4] != sel_q) err_d = 1'b1;
`endif
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (can_pop) begin
            state_d = S_POP;
            sel_d   = pick;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset discards any captured word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b1;
      data_q  <= 6'd0;
      valid_q <= 1'b0;
      src_q   <= 1'b0;
      cnt0_q  <= 8'd0;
      cnt1_q  <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      src_q   <= src_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      done_q  <= done_d;
    end
  end

`ifdef DRAIN_ROUTE_CHECK_EN
  // Sticky route-mismatch flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign error_out = err_q;
`else
  assign error_out = 1'b0;
`endif

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign src_out   = src_q;
  assign count_D0  = cnt0_q;
  assign count_D1  = cnt1_q;
  assign done_out  = done_q;

endmodule

// File: tb/tb_pcie_drain.sv
// Directed bench for pcie_drain. It includes a small behavioural model of the
// two FIFOs: read data appears the cycle after a pop.
module tb_pcie_drain;

  logic       clk = 1'b0;
  logic       reset, enable, idle_in, out_ready;
  logic       empty_D0, empty_D1;
  logic [5:0] data_in0 = '0;
  logic [5:0] data_in1 = '0;
  logic       pop_D0, pop_D1, valid_out, src_out, done_out, error_out;
  logic [5:0] data_out;
  logic [7:0] count_D0, count_D1;

`ifdef DRAIN_ROUTE_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  logic [5:0] mem0 [0:511];
  logic [5:0] mem1 [0:511];
  int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
  int cyc = 0;

  int pop_src [0:1023];
  int pop_cyc [0:1023];
  int npop = 0;
  logic [5:0] wlog [0:1023];
  int nw = 0;
  logic vprev = 1'b0;

  int b, w;

  assign empty_D0 = (wr0 == rd0);
  assign empty_D1 = (wr1 == rd1);

  pcie_drain dut (
    .clk(clk), .reset(reset), .enable(enable),
    .empty_D0(empty_D0), .empty_D1(empty_D1),
    .data_in0(data_in0), .data_in1(data_in1),
    .idle_in(idle_in), .out_ready(out_ready),
    .pop_D0(pop_D0), .pop_D1(pop_D1),
    .data_out(data_out), .valid_out(valid_out), .src_out(src_out),
    .count_D0(count_D0), .count_D1(count_D1),
    .done_out(done_out), .error_out(error_out)
  );

  always #5 clk = ~clk;

  // FIFO model: a pop returns the head word on the next cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pop_D0) begin
      data_in0 <= mem0[rd0];
      rd0      <= rd0 + 1;
    end
    if (pop_D1) begin
      data_in1 <= mem1[rd1];
      rd1      <= rd1 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Continuous protocol checks and logging of pops and emitted words.
  always @(negedge clk) begin
    if (!reset) begin
      chk("pop_exclusive", {31'd0, pop_D0 & pop_D1}, 32'd0);
      chk("pop_empty_d0", {31'd0, pop_D0 & empty_D0}, 32'd0);
      chk("pop_empty_d1", {31'd0, pop_D1 & empty_D1}, 32'd0);
      if (pop_D0 | pop_D1) begin
        pop_src[npop] = pop_D1 ? 1 : 0;
        pop_cyc[npop] = cyc;
        npop++;
      end
      if (valid_out && !vprev) begin
        wlog[nw] = data_out;
        nw++;
      end
    end
    vprev = valid_out;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push0(input logic [5:0] v);
    mem0[wr0] = v;
    wr0 = wr0 + 1;
  endtask

  task automatic push1(input logic [5:0] v);
    mem1[wr1] = v;
    wr1 = wr1 + 1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; idle_in = 1'b1; out_ready = 1'b1;

    // reset state
    tick(); tick();
    chk("rst_pop0", pop_D0, 0);
    chk("rst_pop1", pop_D1, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_src", src_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_cnt0", count_D0, 0);
    chk("rst_cnt1", count_D1, 0);
    chk("rst_done", done_out, 0);
    chk("rst_err", error_out, 0);
    reset = 1'b0;
    tick();
    chk("done_idle", done_out, 1);

    // single word from D0: pop at N, valid at N+2
    push0(6'b011011);
    tick();
    chk("t1_pop_n", pop_D0, 1);
    chk("t1_pop1_n", pop_D1, 0);
    chk("t1_done_busy", done_out, 0);
    tick();
    chk("t1_pop_n1", pop_D0, 0);
    chk("t1_valid_n1", valid_out, 0);
    tick();
    chk("t1_valid_n2", valid_out, 1);
    chk("t1_data", data_out, 6'b011011);
    chk("t1_src", src_out, 0);
    chk("t1_cnt0", count_D0, 1);
    tick();
    chk("t1_valid_drop", valid_out, 0);

    // round-robin with both FIFOs loaded
    do_reset();
    b = npop; w = nw;
    push0(6'b000001); push0(6'b100010);
    push1(6'b010011); push1(6'b110100);
    repeat (15) tick();
    chk("rr_npop", npop - b, 4);
    chk("rr_order0", pop_src[b],   0);
    chk("rr_order1", pop_src[b+1], 1);
    chk("rr_order2", pop_src[b+2], 0);
    chk("rr_order3", pop_src[b+3], 1);
    chk("rr_rate", pop_cyc[b+1] - pop_cyc[b], 3);
    chk("rr_nwords", nw - w, 4);
    chk("rr_w0", wlog[w],   6'b000001);
    chk("rr_w1", wlog[w+1], 6'b010011);
    chk("rr_w2", wlog[w+2], 6'b100010);
    chk("rr_w3", wlog[w+3], 6'b110100);
    chk("rr_cnt0", count_D0, 2);
    chk("rr_cnt1", count_D1, 2);

    // backpressure: hold for 5 cycles
    out_ready = 1'b0;
    push0(6'b001010); push1(6'b011100);
    tick();
    chk("bp_pop0", pop_D0, 1);
    tick(); tick();
    chk("bp_valid", valid_out, 1);
    chk("bp_data", data_out, 6'b001010);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_data", data_out, 6'b001010);
      chk("bp_hold_valid", valid_out, 1);
      chk("bp_hold_pops", {pop_D0, pop_D1}, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_gap_valid", valid_out, 0);
    chk("bp_next_pop1", pop_D1, 1);
    tick(); tick();
    chk("bp_w2_data", data_out, 6'b011100);
    chk("bp_w2_src", src_out, 1);
    chk("bp_cnt0", count_D0, 3);
    chk("bp_cnt1", count_D1, 3);
    tick();

    // enable low blocks new pops
    enable = 1'b0;
    push0(6'b000111);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en_blocked", pop_D0, 0);
    end
    enable = 1'b1;
    tick();
    chk("en_pop", pop_D0, 1);
    tick(); tick();
    chk("en_data", data_out, 6'b000111);
    chk("en_cnt0", count_D0, 4);
    tick();

    // route check
    do_reset();
    push0(6'b101101); push0(6'b111011);
    tick(); tick(); tick();
    chk("rc_w0", data_out, 6'b101101);
    chk("rc_err0", error_out, 0);
    tick(); tick(); tick();
    chk("rc_w1", data_out, 6'b111011);
    chk("rc_err1", error_out, EXP_ERR);
    tick(); tick();
    chk("rc_err_sticky", error_out, EXP_ERR);
    do_reset();
    chk("rc_err_cleared", error_out, 0);

    // count saturation
    for (int i = 0; i < 260; i++) push1(i[5:0] | 6'b010000);
    repeat (800) tick();
    chk("sat_drained", empty_D1, 1);
    chk("sat_cnt1", count_D1, 255);
    chk("sat_cnt0", count_D0, 0);
    chk("sat_valid", valid_out, 0);

    // reset during HOLD restores D0 priority
    do_reset();
    out_ready = 1'b0;
    push0(6'b001001);
    tick(); tick(); tick();
    chk("rh_valid", valid_out, 1);
    chk("rh_cnt0", count_D0, 1);
    push0(6'b000101); push1(6'b010110);
    reset = 1'b1;
    tick();
    chk("rh_valid_clr", valid_out, 0);
    chk("rh_cnt0_clr", count_D0, 0);
    chk("rh_cnt1_clr", count_D1, 0);
    chk("rh_data_clr", data_out, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("rh_first_d0", pop_D0, 1);
    chk("rh_first_not_d1", pop_D1, 0);
    repeat (10) tick();
    chk("rh_cnt0_end", count_D0, 1);
    chk("rh_cnt1_end", count_D1, 1);
    chk("done_end", done_out, 1);
    idle_in = 1'b0;
    tick(); tick();
    chk("done_idle_in_low", done_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcie_drain.md
PCIE_DRAIN -- requirements
Module: pcie_drain

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all logic on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: enable  in  1  permits new pops when high.
REQ-004 SHALL have: empty_D0 / empty_D1  in  1 each  destination FIFO empty flags.
REQ-005 SHALL have: data_in0 / data_in1  in  6 each  FIFO read data; {VC, D, data[3:0]}, valid the cycle after the pop.
REQ-006 SHALL have: idle_in  in  1  idle status from the transaction block.
REQ-007 SHALL have: out_ready  in  1  downstream accepts data_out.
REQ-008 SHALL have: pop_D0 / pop_D1  out  1 each  single-cycle FIFO pop strobes.
REQ-009 SHALL have: data_out  out  6  captured word; valid_out  out  1; src_out  out  1  (0=D0, 1=D1).
REQ-010 SHALL have: count_D0 / count_D1  out  8 each  words drained per destination.
REQ-011 SHALL have: done_out  out  1; error_out  out  1.

Function
REQ-012 SHALL implement FSM states IDLE, POP, CAPTURE and HOLD.
REQ-013 IDLE: if enable and any FIFO is non-empty, SHALL go to POP; otherwise stays in IDLE.
REQ-014 POP: SHALL assert exactly one pop strobe for exactly one cycle, then go to CAPTURE.
REQ-015 SHALL arbitrate round-robin: on a tie, serve the FIFO not served last; after reset, D0 wins first.
REQ-016 SHALL never pop an empty FIFO; pop_D0 and pop_D1 SHALL never be high together.
REQ-017 CAPTURE: SHALL register the selected data_inX into data_out, set src_out, assert valid_out, increment the matching count, then go to HOLD.
REQ-018 HOLD: SHALL keep data_out/src_out/valid_out stable until out_ready is high.
REQ-019 HOLD exit: on out_ready with another pop permitted, SHALL go to POP, so valid_out drops for one cycle; otherwise SHALL go to IDLE with valid_out low.
REQ-020 Latency SHALL be pop strobe at cycle N, valid_out at cycle N+2; sustained throughput is one word per 3 cycles.
REQ-021 count_D0/count_D1 SHALL saturate at 255 and not wrap.
REQ-022 enable low SHALL only block new POP entries; a word in CAPTURE/HOLD SHALL complete normally.
REQ-023 An empty flag rising while in POP SHALL not cancel the pop already issued.
REQ-024 done_out SHALL be high exactly when FSM is IDLE, idle_in=1, empty_D0=1 and empty_D1=1, registered one cycle.

Reset
REQ-025 With reset high at a clock edge, SHALL enter IDLE with all outputs 0: pops, valid_out, src_out, data_out, counts, done_out, error_out.
REQ-026 Reset mid-transfer SHALL discard any captured word and restore round-robin priority to D0.

Configuration
REQ-027 Macro DRAIN_ROUTE_CHECK_EN defined: at CAPTURE, SHALL set sticky error_out when data bit4 differs from src_out; only reset clears it.
REQ-028 Macro undefined: error_out SHALL be constant 0 and no check logic is present; all other behaviour is identical.

Verification
REQ-029 Reset, then empty_D0=0, word 6'b011011 presented on D0 with out_ready=1 -> pop_D0 pulse at N, data_out=6'b011011, src_out=0, valid_out at N+2, count_D0=1.
REQ-030 Both FIFOs non-empty, two words each, out_ready=1 -> pop order D0,D1,D0,D1; no simultaneous pops; counts 2/2.
REQ-031 out_ready=0 for 5 cycles during HOLD -> data_out held constant and no pops issued; one word emitted when ready rises.
REQ-032 DRAIN_ROUTE_CHECK_EN defined, D0 supplies 6'b101101 (bit4=0, correct) then 6'b111011 (bit4=1) -> error_out rises after the second capture and stays high; with the macro undefined it stays 0.
REQ-033 Drain 260 words from D1 -> count_D1 stops at 255.
REQ-034 Assert reset during HOLD -> next cycle valid_out=0 and counts=0; first pop after release goes to D0 when both are non-empty.
